// File: rtl/regs_wr_arbiter.sv
// Round-robin write-port arbiter for the 4x8 register bank.
// Source A is the ALU writeback path and source B is the memory-load path.
// The grant is registered, so the bank sees one clean wr_en cycle per grant.
module regs_wr_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              stall_a,
  output logic              stall_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {StIdle, StWrA, StWrB} state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;  // 0: A wins a tie, 1: B wins a tie
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              elig_a, elig_b;

  // State and captured write registers; async reset clears any in-flight write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state: pick the next source, capture its operands, rotate priority.
  always_comb begin
    state_d   = StIdle;
    rr_ptr_d  = rr_ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // A source being granted now drops its request next cycle, so mask it.
    elig_a    = req_a & ~gnt_a;
    elig_b    = req_b & ~gnt_b;

    if (!flush) begin
      if (elig_a && elig_b) begin
        state_d = rr_ptr_q ? StWrB : StWrA;
      end else if (elig_a) begin
        state_d = StWrA;
      end else if (elig_b) begin
        state_d = StWrB;
      end
    end

    case (state_d)
      StWrA: begin
        wr_addr_d = addr_a;
        wr_data_d = data_a;
        rr_ptr_d  = 1'b1;
      end
      StWrB: begin
        wr_addr_d = addr_b;
        wr_data_d = data_b;
        rr_ptr_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs: grants decode the state register; stalls combine live requests.
  always_comb begin
    gnt_a   = (state_q == StWrA);
    gnt_b   = (state_q == StWrB);
    wr_en   = gnt_a | gnt_b;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
    stall_a = req_a & ~gnt_a;
    stall_b = req_b & ~gnt_b;
  end

endmodule
